// File: rtl/SOPHON_PKG.sv
// Shared LSU bus types: the request/response channel between initiators and the DRAM arbiter.
package SOPHON_PKG;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  strb;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] rdata;
    } lsu_ack_t;

    localparam logic [3:0]  LSU_STRB_WORD  = 4'hF;
    localparam logic [31:0] LSU_WORD_BYTES = 32'd4;

endpackage

// File: rtl/dma_lsu_initiator.sv
// Word-granular DMA engine: copies src->dst or fills dst with a pattern over one LSU port.
// Copy is read/capture/write per word; fill is a write per cycle with zero-wait acks.
module dma_lsu_initiator
    import SOPHON_PKG::*;
#(
    parameter int MAX_LEN_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [MAX_LEN_W-1:0] len_i,
    input  logic [31:0]          pattern_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output lsu_req_t             dram_req_o,
    input  lsu_ack_t             dram_ack_i
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_mode;
    logic [31:0]            r_src;
    logic [31:0]            r_dst;
    logic [MAX_LEN_W-1:0]   r_cnt;
    logic [31:0]            r_data;
    logic [31:0]            r_pattern;
    logic                   r_err;

    logic w_start;
    logic w_ack_ok;
    logic w_ack_err;

    // Acks only count while a request is actually on the bus.
    assign w_start   = (r_state == IDLE) && start_i;
    assign w_ack_ok  = dram_req_o.req && dram_ack_i.ack && !dram_ack_i.error;
    assign w_ack_err = dram_req_o.req && dram_ack_i.ack && dram_ack_i.error;

    assign busy_o = (r_state != IDLE) || start_i;
    assign done_o = (r_state == DONE);
    assign err_o  = r_err;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and bus request; request fields are zero whenever req is low.
    always_comb begin
        w_next     = r_state;
        dram_req_o = '0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) w_next = DONE;
                    else if (mode_i) w_next = WR_REQ;
                    else             w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                dram_req_o.req  = 1'b1;
                dram_req_o.addr = r_src;
                dram_req_o.strb = LSU_STRB_WORD;
                if (dram_ack_i.ack) w_next = dram_ack_i.error ? DONE : RD_DATA;
            end
            RD_DATA: w_next = WR_REQ;
            WR_REQ: begin
                dram_req_o.req   = 1'b1;
                dram_req_o.we    = 1'b1;
                dram_req_o.addr  = r_dst;
                dram_req_o.strb  = LSU_STRB_WORD;
                dram_req_o.wdata = r_mode ? r_pattern : r_data;
                if (dram_ack_i.ack) begin
                    if (dram_ack_i.error || r_cnt == MAX_LEN_W'(1)) w_next = DONE;
                    else if (r_mode)                                 w_next = WR_REQ;
                    else                                             w_next = RD_REQ;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Config latch, read-data capture, per-word advance and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode    <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_pattern <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_start) begin
                r_err <= 1'b0;
                if (len_i != '0) begin
                    r_mode    <= mode_i;
                    r_src     <= src_addr_i;
                    r_dst     <= dst_addr_i;
                    r_cnt     <= len_i;
                    r_pattern <= pattern_i;
                end
            end
            // rdata arrives the cycle after the read ack
            if (r_state == RD_DATA) r_data <= dram_ack_i.rdata;
            if (r_state == WR_REQ && w_ack_ok) begin
                r_src <= r_src + LSU_WORD_BYTES;
                r_dst <= r_dst + LSU_WORD_BYTES;
                r_cnt <= r_cnt - MAX_LEN_W'(1);
            end
            if (w_ack_err) r_err <= 1'b1;
        end
    end

endmodule
